// File: rtl/mem_access_pkg.sv
// Shared types and widths for the unified-memory access unit.
package mem_access_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    // Byte address to word index; the two top index bits are forced to zero.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return {2'b00, addr[ADDR_W-1:2]};
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Single-port memory arbiter for instruction fetch and load/store traffic.
// Define MEM_ACCESS_ALIGN_CHECK_EN to also fault on misaligned addresses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_RD,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              err
);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_t            state, state_next;
    logic              accept;
    logic              accept_store;
    logic [ADDR_W-1:0] sel_addr;
    logic              accept_fault;
    logic              fault_q;     // fault status of the access in flight

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        accept_store = 1'b0;
        sel_addr     = pc;
        case (state)
            IDLE: begin
                // Data accesses win; a colliding fetch stays pending at the requester.
                if (ls_req) begin
                    accept       = 1'b1;
                    accept_store = ls_write;
                    sel_addr     = ls_addr;
                    state_next   = ls_write ? STORE : LOAD;
                end else if (fetch_req) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH, LOAD, STORE: state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    assign accept_fault = (word_index(sel_addr) >= ADDR_W'(MEM_WORDS))
                        || (ALIGN_CHECK && (sel_addr[1:0] != 2'b00));

    // Decoded from state so an asynchronous reset removes the strobe at once.
    assign mem_write = (state == STORE) && !fault_q;
    assign busy      = (state != IDLE);

    // NOTE: all state below uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fault_q     <= 1'b0;
            mem_address <= '0;
            mem_WD      <= '0;
            instr       <= '0;
            rdata       <= '0;
            instr_valid <= 1'b0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            instr_valid <= 1'b0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;

            if (accept) begin
                mem_address <= word_index(sel_addr);
                fault_q     <= accept_fault;
                if (accept_store) begin
                    mem_WD <= ls_wdata;
                end
            end

            case (state)
                FETCH: begin
                    instr       <= fault_q ? '0 : mem_RD;
                    instr_valid <= 1'b1;
                    err         <= fault_q;
                end
                LOAD: begin
                    rdata       <= fault_q ? '0 : mem_RD;
                    rdata_valid <= 1'b1;
                    err         <= fault_q;
                end
                STORE:   err <= fault_q;
                default: ;
            endcase
        end
    end

endmodule
